// File: rtl/mux_4to1_pkg.sv
// Shared CPU datapath definitions: word width and named select codes
// for the 4-input datapath selector.
package mux_4to1_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

endpackage : mux_4to1_pkg

// File: rtl/mux_4to1.sv
// 4-input datapath selector. It has two outputs:
//   - out: zero-latency combinational output, for use within the same cycle.
//   - out_q: registered copy, for pipeline-stage boundaries. It comes with a
//     valid flag, the captured select, and a select-change pulse.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic [1:0]       sel_q,
  output logic             sel_changed
);

  // Combinational select of one data input by control.
  always_comb begin
    // NOTE: every path assigns out. The default arm covers an X/Z control,
    // so no latch is inferred, and the X propagates in simulation.
    case (control)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = 'x;
    endcase
  end

  // Output register. Reset has priority, then capture on en.
  // When en is low the register holds; the change pulse lasts one cycle only.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. sel_changed
    // therefore compares control with the sel_q and out_valid values from
    // before this edge.
    if (rst) begin
      out_q       <= '0;
      sel_q       <= SEL_A;
      out_valid   <= 1'b0;
      sel_changed <= 1'b0;
    end else if (en) begin
      out_q       <= out;
      sel_q       <= control;
      out_valid   <= 1'b1;
      sel_changed <= out_valid && (control != sel_q);
    end else begin
      sel_changed <= 1'b0;
    end
  end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1. The reference model is a plain
// array-indexed select plus a small register model of the capture rules.
module tb_mux_4to1;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   control;
  logic [W-1:0] a, b, c, d;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         out_valid;
  logic [1:0]   sel_q;
  logic         sel_changed;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state for the registered outputs.
  logic [W-1:0] m_q;
  logic [1:0]   m_sel;
  logic         m_valid;
  logic         m_chg;

  mux_4to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .control(control),
    .a(a), .b(b), .c(c), .d(d),
    .out(out), .out_q(out_q), .out_valid(out_valid),
    .sel_q(sel_q), .sel_changed(sel_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference select: index an array of the four inputs.
  function automatic logic [W-1:0] ref_sel(input logic [1:0] s);
    logic [W-1:0] data [4];
    data[0] = a; data[1] = b; data[2] = c; data[3] = d;
    return data[s];
  endfunction

  // Apply the capture rules for the edge that is about to happen.
  task automatic model_edge();
    if (rst) begin
      m_q = '0; m_sel = 2'd0; m_valid = 1'b0; m_chg = 1'b0;
    end else if (en) begin
      m_chg   = m_valid && (control != m_sel);
      m_q     = ref_sel(control);
      m_sel   = control;
      m_valid = 1'b1;
    end else begin
      m_chg = 1'b0;
    end
  endtask

  // Drive inputs at the falling edge, model the rising edge, and then
  // sample 1 ns after it.
  task automatic step(input logic r, input logic e, input logic [1:0] s);
    @(negedge clk);
    rst = r; en = e; control = s;
    #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [W-1:0] exp_vals [4];
    exp_vals[0] = 16'd1; exp_vals[1] = 16'd2; exp_vals[2] = 16'd3; exp_vals[3] = 16'd4;
    a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4;
    for (int i = 0; i < 4; i++) begin
      control = 2'(i);
      #10;
      n_checks++;
      if (out !== exp_vals[i]) begin
        n_fail++;
        $display("FAIL comb_sweep sel=%0d: got %h expected %h", i, out, exp_vals[i]);
      end
    end
  endtask

  task automatic test_data_tracking();
    control = 2'd2;
    #1;
    c = 16'hFFFF;
    #1;
    n_checks++;
    if (out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL track_c: got %h expected ffff", out);
    end
    a = 16'h1234; b = 16'h5678; d = 16'h9ABC;
    #1;
    n_checks++;
    if (out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL track_others: got %h expected ffff", out);
    end
    a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'(i + 1));
      n_checks++;
      if (out_q !== '0 || sel_q !== 2'd0 || out_valid !== 1'b0 || sel_changed !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got q=%h sel=%0d v=%b chg=%b expected all zero",
                 i, out_q, sel_q, out_valid, sel_changed);
      end
      n_checks++;
      if (out !== ref_sel(control)) begin
        n_fail++;
        $display("FAIL reset_comb: got %h expected %h", out, ref_sel(control));
      end
    end
  endtask

  task automatic test_capture();
    logic [1:0]   sels [3];
    logic [W-1:0] exp_q [3];
    logic         exp_chg [3];
    sels[0] = 2'd0; sels[1] = 2'd0; sels[2] = 2'd3;
    exp_q[0] = 16'd1; exp_q[1] = 16'd1; exp_q[2] = 16'd4;
    exp_chg[0] = 1'b0; exp_chg[1] = 1'b0; exp_chg[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, sels[i]);
      n_checks++;
      if (out_q !== exp_q[i] || sel_q !== sels[i] || out_valid !== 1'b1 ||
          sel_changed !== exp_chg[i]) begin
        n_fail++;
        $display("FAIL capture cyc%0d: got q=%h sel=%0d v=%b chg=%b expected q=%h sel=%0d v=1 chg=%b",
                 i, out_q, sel_q, out_valid, sel_changed, exp_q[i], sels[i], exp_chg[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 2'd1);
    n_checks++;
    if (out_q !== 16'd4 || sel_q !== 2'd3 || out_valid !== 1'b1 || sel_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got q=%h sel=%0d v=%b chg=%b expected q=0004 sel=3 v=1 chg=0",
               out_q, sel_q, out_valid, sel_changed);
    end
    n_checks++;
    if (out !== 16'd2) begin
      n_fail++;
      $display("FAIL hold_comb: got %h expected 0002", out);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b1, 2'd2);
    n_checks++;
    if (out_q !== '0 || sel_q !== 2'd0 || out_valid !== 1'b0 || sel_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_priority: got q=%h sel=%0d v=%b chg=%b expected all zero",
               out_q, sel_q, out_valid, sel_changed);
    end
    step(1'b0, 1'b1, 2'd2);
    n_checks++;
    if (out_valid !== 1'b1 || sel_changed !== 1'b0 || out_q !== 16'd3 || sel_q !== 2'd2) begin
      n_fail++;
      $display("FAIL first_after_rst: got q=%h sel=%0d v=%b chg=%b expected q=0003 sel=2 v=1 chg=0",
               out_q, sel_q, out_valid, sel_changed);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      control = 2'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (out !== ref_sel(control)) begin
        n_fail++;
        $display("FAIL rand_comb #%0d: got %h expected %h", i, out, ref_sel(control));
      end
      model_edge();
      @(posedge clk);
      #1;
      n_checks++;
      if (out_q !== m_q || sel_q !== m_sel || out_valid !== m_valid || sel_changed !== m_chg) begin
        n_fail++;
        $display("FAIL rand_reg #%0d: got q=%h sel=%0d v=%b chg=%b expected q=%h sel=%0d v=%b chg=%b",
                 i, out_q, sel_q, out_valid, sel_changed, m_q, m_sel, m_valid, m_chg);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; control = 2'd0;
    a = '0; b = '0; c = '0; d = '0;
    m_q = '0; m_sel = 2'd0; m_valid = 1'b0; m_chg = 1'b0;
    test_comb_sweep();
    test_data_tracking();
    test_reset();
    test_capture();
    test_hold();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_4to1
